hybrid_wrapper_top: RTL and testbench
=====================================

// Module: hybrid_wrapper_top
// PURPOSE
// - Top of the hybrid RISC-V/CGRA system: instruction RAM, bitstream configurator, one-stage CGRA accumulator, processor fetch front-end.
// - Configurator loads a CGRA bitstream from RAM into a serial config chain.
// - The CGRA then runs, and the fetch front-end streams instruction lines from BOOT_ADDR.
// PARAMETERS
// - INSTR_RDATA_WIDTH  128    fetch line width in bits; multiple of 32.
// - BOOT_ADDR          'h180  byte address loaded into pc on core reset.
// - PULP_SECURE        1      reserved; legal values 0/1, no function here.
// - A_EXTENSION        1      reserved; legal values 0/1, no function here.
// - MEM_WORDS          4096   RAM depth in 32-bit words.
// - CFG_BASE           0      word address of the bitstream in RAM.
// - CFG_WORDS          2      bitstream length in words; chain is 32*CFG_WORDS bits.
// PORTS
// - clk_i                in   1     single clock; all logic on its rising edge.
// - Config_Reset         in   1     sync active-high; clears config chain.
// - CGRA_Reset           in   1     sync active-high; clears CGRA accumulator.
// - configurator_reset   in   1     sync active-high; configurator FSM -> IDLE, done=0.
// - rst_ni               in   1     sync active-low core reset; pc<=BOOT_ADDR, fetch valid=0.
// - fetch_enable_i       in   1     core fetch permit.
// - riscv_enable         in   1     core run gate; ANDed with fetch_enable_i.
// - Config_Clock_en      in   1     chain shifts only when 1.
// - CGRA_Clock_en        in   1     accumulator updates only when 1.
// - configurator_enable  in   1     start/continue bitstream load.
// - configurator_done    out  1     sticky 1 after the last chain bit shifts in.
// - instr_rdata_o        out  IRW   registered fetch line.
// - instr_valid_o        out  1     1 the cycle after a fetch.
// - pc_o                 out  32    current fetch byte address.
// - cgra_result_o        out  32    CGRA accumulator.
// BEHAVIOUR
// - Single clock; every reset is synchronous.
// - Config_Reset, CGRA_Reset and configurator_reset are active-high.
// - rst_ni is active-low.
// - Reset values: done=0, chain=0, acc=0, pc=BOOT_ADDR, instr_valid_o=0, instr_rdata_o=0.
// - RAM: hierarchy ram_i.instruc_ram_i.mem[0:MEM_WORDS-1] of 32 bits, preloadable by $readmemh; no write port.
// - Word address wraps modulo MEM_WORDS.
// - Configurator FSM states: IDLE, LOAD, SHIFT, DONE.
//   - IDLE -> LOAD when configurator_enable.
//   - LOAD: latch word mem[CFG_BASE+w] into a shift register, bit counter=0 -> SHIFT.
//   - SHIFT: when Config_Clock_en & configurator_enable, shift the word's LSB into chain[MSB]; the chain shifts right.
//   - After 32 bits: w++ -> LOAD, or -> DONE when w==CFG_WORDS-1.
//   - DONE: configurator_done=1, held until configurator_reset, even if configurator_enable drops.
//   - enable=0 in SHIFT stalls without loss.
// - Chain decode once done: op=chain[1:0], operand=chain[63:32].
//   - After the full load, word0 sits in chain[31:0].
// - CGRA: when CGRA_Clock_en & ~CGRA_Reset & configurator_done, acc <= acc OP operand, mod 2^32.
//   - OP: 00 add, 01 sub, 10 xor, 11 mul (low 32 bits).
//   - CGRA_Reset has priority over enable.
// - Fetch: when rst_ni & riscv_enable & fetch_enable_i:
//   - instr_rdata_o <= {mem[a+k-1]..mem[a]}, k=IRW/32, a=pc>>2.
//   - instr_valid_o <= 1; pc <= pc + IRW/8.
//   - Otherwise instr_valid_o <= 0, pc holds.
//   - BOOT_ADDR is line-aligned.
// - Simultaneous: configurator_reset beats enable.
// - Config_Reset mid-load clears the chain only; the FSM continues, so the bitstream is corrupt and the system must be reset together.
// TESTING
// - mem[0]=0x00000000 (add), mem[1]=5; reset, enable with Config_Clock_en=1 -> done asserts 1+2*(1+32) cycles after start; chain=64'h00000005_00000000.
// - After done, CGRA_Clock_en=1 for 3 cycles -> cgra_result_o=15; then CGRA_Reset 1 cycle -> 0.
// - Op 11, operand 3, acc preset by 2 add cycles of 3 -> acc 6; one mul cycle -> 18.
// - mem[0x60..0x63]=1,2,3,4, rst_ni low then riscv_enable=1 -> first instr_rdata_o=0x00000004_00000003_00000002_00000001, pc 0x180->0x190.
// - Config_Clock_en=0 mid SHIFT for 10 cycles -> no progress, load completes correctly after re-enable.
// - configurator_reset while DONE -> done=0 next cycle, FSM IDLE, acc updates blocked.

Source files
------------

// File: rtl/hybrid_wrapper_top.sv
// Hybrid RISC-V/CGRA system top: instruction RAM, bitstream configurator,
// serial config chain, one-stage CGRA accumulator and fetch front-end.
//
// Ports:
//   clk_i               single clock, all logic on the rising edge
//   Config_Reset        sync active-high, clears the config chain
//   CGRA_Reset          sync active-high, clears the CGRA accumulator
//   configurator_reset  sync active-high, configurator FSM to IDLE, done=0
//   rst_ni              sync active-low core reset (pc, fetch outputs)
//   fetch_enable_i      core fetch permit
//   riscv_enable        core run gate, ANDed with fetch_enable_i
//   Config_Clock_en     chain shifts only when high
//   CGRA_Clock_en       accumulator updates only when high
//   configurator_enable start/continue bitstream load
//   configurator_done   sticky high once the last chain bit is in
//   instr_rdata_o       registered fetch line
//   instr_valid_o       high the cycle after a fetch
//   pc_o                current fetch byte address
//   cgra_result_o       CGRA accumulator

// Word-addressed instruction memory with a configurator read port and a
// multi-word fetch read port. Addresses wrap modulo MEM_WORDS.
module instruc_ram #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned K         = 4
) (
    input  logic                        clk,
    input  logic                        we,
    input  logic [$clog2(MEM_WORDS)-1:0] waddr,
    input  logic [31:0]                 wdata,
    input  logic [31:0]                 cfg_addr,
    output logic [31:0]                 cfg_data,
    input  logic [31:0]                 fetch_addr,
    output logic [K*32-1:0]             fetch_line
);
    localparam int unsigned AW = $clog2(MEM_WORDS);

    logic [31:0] mem [0:MEM_WORDS-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign cfg_data = mem[AW'(cfg_addr % MEM_WORDS)];

    // Word i of the line comes from a+i; word 0 lands in the low bits.
    for (genvar i = 0; i < K; i++) begin : g_line
        assign fetch_line[i*32 +: 32] =
            mem[AW'((fetch_addr + 32'(i)) % MEM_WORDS)];
    end
endmodule

// RAM wrapper: the array is preloaded externally, so the write port of the
// storage macro is tied off here.
module hybrid_ram #(
    parameter int unsigned MEM_WORDS = 4096,
    parameter int unsigned K         = 4
) (
    input  logic            clk,
    input  logic [31:0]     cfg_addr,
    output logic [31:0]     cfg_data,
    input  logic [31:0]     fetch_addr,
    output logic [K*32-1:0] fetch_line
);
    instruc_ram #(
        .MEM_WORDS (MEM_WORDS),
        .K         (K)
    ) instruc_ram_i (
        .clk        (clk),
        .we         (1'b0),
        .waddr      ('0),
        .wdata      (32'h0),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .fetch_addr (fetch_addr),
        .fetch_line (fetch_line)
    );
endmodule

module hybrid_wrapper_top #(
    parameter int unsigned INSTR_RDATA_WIDTH = 128,
    parameter logic [31:0] BOOT_ADDR         = 32'h180,
    parameter int unsigned PULP_SECURE       = 1,
    parameter int unsigned A_EXTENSION       = 1,
    parameter int unsigned MEM_WORDS         = 4096,
    parameter int unsigned CFG_BASE          = 0,
    parameter int unsigned CFG_WORDS         = 2
) (
    input  logic                         clk_i,
    input  logic                         Config_Reset,
    input  logic                         CGRA_Reset,
    input  logic                         configurator_reset,
    input  logic                         rst_ni,
    input  logic                         fetch_enable_i,
    input  logic                         riscv_enable,
    input  logic                         Config_Clock_en,
    input  logic                         CGRA_Clock_en,
    input  logic                         configurator_enable,
    output logic                         configurator_done,
    output logic [INSTR_RDATA_WIDTH-1:0] instr_rdata_o,
    output logic                         instr_valid_o,
    output logic [31:0]                  pc_o,
    output logic [31:0]                  cgra_result_o
);
    localparam int unsigned K  = INSTR_RDATA_WIDTH / 32;
    localparam int unsigned CW = 32 * CFG_WORDS;
    localparam int unsigned WW = (CFG_WORDS > 1) ? $clog2(CFG_WORDS) : 1;
    localparam logic [WW-1:0] LAST_WORD = WW'(CFG_WORDS - 1);
    localparam logic [31:0] LINE_BYTES = 32'(INSTR_RDATA_WIDTH / 8);

    // Reserved knobs only accept 0/1; anything else keeps the core parked.
    localparam logic RSVD_OK = (PULP_SECURE <= 1) && (A_EXTENSION <= 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]     state;
    logic [WW-1:0]  word_idx;
    logic [4:0]     bit_cnt;
    logic [31:0]    sreg;
    logic           done;
    logic [CW-1:0]  chain;
    logic           shift_en;

    logic [31:0]    cfg_addr;
    logic [31:0]    cfg_data;
    logic [31:0]    fetch_addr;
    logic [K*32-1:0] fetch_line;

    logic [1:0]     op;
    logic [31:0]    operand;
    logic [31:0]    acc;
    logic [31:0]    alu;

    logic [31:0]    pc;
    logic           run;

    // ---------------- RAM ----------------
    assign cfg_addr   = 32'(CFG_BASE) + 32'(word_idx);
    assign fetch_addr = pc >> 2;

    hybrid_ram #(
        .MEM_WORDS (MEM_WORDS),
        .K         (K)
    ) ram_i (
        .clk        (clk_i),
        .cfg_addr   (cfg_addr),
        .cfg_data   (cfg_data),
        .fetch_addr (fetch_addr),
        .fetch_line (fetch_line)
    );

    // ---------------- Configurator ----------------
    // A shift happens only in SHIFT with both enables; a concurrent
    // configurator reset wins and suppresses the shift.
    assign shift_en = (state == SHIFT) && Config_Clock_en &&
                      configurator_enable && !configurator_reset;

    always_ff @(posedge clk_i) begin
        if (configurator_reset) begin
            state    <= IDLE;
            done     <= 1'b0;
            word_idx <= '0;
            bit_cnt  <= '0;
            sreg     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (configurator_enable) begin
                        state    <= LOAD;
                        word_idx <= '0;
                    end
                end
                LOAD: begin
                    sreg    <= cfg_data;
                    bit_cnt <= '0;
                    state   <= SHIFT;
                end
                SHIFT: begin
                    if (shift_en) begin
                        sreg    <= sreg >> 1;
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'd31) begin
                            if (word_idx == LAST_WORD) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                word_idx <= word_idx + 1'b1;
                                state    <= LOAD;
                            end
                        end
                    end
                end
                DONE: begin
                    done <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Chain shifts right, new bit at the MSB: the first word loaded ends
    // up in the low 32 bits once the whole bitstream is in.
    always_ff @(posedge clk_i) begin
        if (Config_Reset) begin
            chain <= '0;
        end else if (shift_en) begin
            chain <= {sreg[0], chain[CW-1:1]};
        end
    end

    assign configurator_done = done;

    // ---------------- CGRA ----------------
    assign op      = chain[1:0];
    assign operand = chain[63:32];

    always_comb begin
        alu = acc;
        unique case (op)
            2'b00: alu = acc + operand;
            2'b01: alu = acc - operand;
            2'b10: alu = acc ^ operand;
            2'b11: alu = acc * operand;
            default: alu = acc;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (CGRA_Reset) begin
            acc <= '0;
        end else if (CGRA_Clock_en && done) begin
            acc <= alu;
        end
    end

    assign cgra_result_o = acc;

    // ---------------- Fetch front-end ----------------
    assign run = riscv_enable && fetch_enable_i && RSVD_OK;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc            <= BOOT_ADDR;
            instr_valid_o <= 1'b0;
            instr_rdata_o <= '0;
        end else if (run) begin
            instr_rdata_o <= fetch_line;
            instr_valid_o <= 1'b1;
            pc            <= pc + LINE_BYTES;
        end else begin
            instr_valid_o <= 1'b0;
        end
    end

    assign pc_o = pc;
endmodule

// File: tb/tb_hybrid_wrapper_top.sv
// Directed testbench for hybrid_wrapper_top: bitstream load timing, chain
// contents, CGRA ops, stall behaviour, configurator reset and fetch.
module tb_hybrid_wrapper_top;
    logic         clk_i = 1'b0;
    logic         Config_Reset;
    logic         CGRA_Reset;
    logic         configurator_reset;
    logic         rst_ni;
    logic         fetch_enable_i;
    logic         riscv_enable;
    logic         Config_Clock_en;
    logic         CGRA_Clock_en;
    logic         configurator_enable;
    logic         configurator_done;
    logic [127:0] instr_rdata_o;
    logic         instr_valid_o;
    logic [31:0]  pc_o;
    logic [31:0]  cgra_result_o;

    int n_vec = 0;
    int n_bad = 0;
    int cyc;

    always #5 clk_i = ~clk_i;

    hybrid_wrapper_top dut (
        .clk_i               (clk_i),
        .Config_Reset        (Config_Reset),
        .CGRA_Reset          (CGRA_Reset),
        .configurator_reset  (configurator_reset),
        .rst_ni              (rst_ni),
        .fetch_enable_i      (fetch_enable_i),
        .riscv_enable        (riscv_enable),
        .Config_Clock_en     (Config_Clock_en),
        .CGRA_Clock_en       (CGRA_Clock_en),
        .configurator_enable (configurator_enable),
        .configurator_done   (configurator_done),
        .instr_rdata_o       (instr_rdata_o),
        .instr_valid_o       (instr_valid_o),
        .pc_o                (pc_o),
        .cgra_result_o       (cgra_result_o)
    );

    task automatic check(input string tag, input logic [127:0] got,
                         input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Restart the configurator with a clean chain, then load w0/w1.
    // Optionally drops Config_Clock_en for stall_len cycles.
    task automatic load_cfg(input logic [31:0] w0, input logic [31:0] w1,
                            input int stall_at, input int stall_len,
                            output int cycles);
        dut.ram_i.instruc_ram_i.mem[0] = w0;
        dut.ram_i.instruc_ram_i.mem[1] = w1;
        @(negedge clk_i);
        configurator_enable = 1'b0;
        configurator_reset  = 1'b1;
        Config_Reset        = 1'b1;
        @(negedge clk_i);
        configurator_reset  = 1'b0;
        Config_Reset        = 1'b0;
        Config_Clock_en     = 1'b1;
        configurator_enable = 1'b1;
        cycles = 0;
        while (configurator_done !== 1'b1 && cycles < 300) begin
            if (cycles == stall_at) Config_Clock_en = 1'b0;
            if (cycles == stall_at + stall_len) Config_Clock_en = 1'b1;
            @(posedge clk_i);
            #1;
            cycles++;
        end
        Config_Clock_en = 1'b1;
    endtask

    task automatic cgra_run(input int n);
        @(negedge clk_i);
        CGRA_Clock_en = 1'b1;
        repeat (n) @(negedge clk_i);
        CGRA_Clock_en = 1'b0;
    endtask

    initial begin
        Config_Reset        = 1'b1;
        CGRA_Reset          = 1'b1;
        configurator_reset  = 1'b1;
        rst_ni              = 1'b0;
        fetch_enable_i      = 1'b0;
        riscv_enable        = 1'b0;
        Config_Clock_en     = 1'b0;
        CGRA_Clock_en       = 1'b0;
        configurator_enable = 1'b0;
        for (int i = 0; i < 4096; i++) begin
            dut.ram_i.instruc_ram_i.mem[i] = 32'h0;
        end
        for (int i = 0; i < 8; i++) begin
            dut.ram_i.instruc_ram_i.mem[32'h60 + i] = 32'(i + 1);
        end
        repeat (2) @(negedge clk_i);
        Config_Reset       = 1'b0;
        CGRA_Reset         = 1'b0;
        configurator_reset = 1'b0;
        rst_ni             = 1'b1;

        check("rst_done",  128'(configurator_done), 128'h0);
        check("rst_acc",   128'(cgra_result_o), 128'h0);
        check("rst_pc",    128'(pc_o), 128'h180);
        check("rst_valid", 128'(instr_valid_o), 128'h0);
        check("rst_rdata", instr_rdata_o, 128'h0);
        check("rst_chain", 128'(dut.chain), 128'h0);

        // add 5: load timing and chain layout
        load_cfg(32'h0, 32'h5, -1, 0, cyc);
        check("load_cycles", 128'(cyc), 128'd67);
        check("load_chain", 128'(dut.chain), 128'h00000005_00000000);
        configurator_enable = 1'b0;
        @(negedge clk_i);
        check("done_sticky", 128'(configurator_done), 128'h1);

        cgra_run(3);
        check("add3x5", 128'(cgra_result_o), 128'd15);
        @(negedge clk_i);
        CGRA_Reset = 1'b1;
        @(negedge clk_i);
        CGRA_Reset = 1'b0;
        check("cgra_rst", 128'(cgra_result_o), 128'h0);

        // add 3 twice, then mul 3, sub 3, xor F0
        load_cfg(32'h0, 32'h3, -1, 0, cyc);
        cgra_run(2);
        check("add2x3", 128'(cgra_result_o), 128'd6);
        load_cfg(32'h3, 32'h3, -1, 0, cyc);
        check("acc_hold_load", 128'(cgra_result_o), 128'd6);
        cgra_run(1);
        check("mul3", 128'(cgra_result_o), 128'd18);
        load_cfg(32'h1, 32'h3, -1, 0, cyc);
        cgra_run(1);
        check("sub3", 128'(cgra_result_o), 128'd15);
        load_cfg(32'h2, 32'hF0, -1, 0, cyc);
        cgra_run(1);
        check("xorF0", 128'(cgra_result_o), 128'hFF);

        // stall 10 cycles inside the first word's shift phase
        load_cfg(32'h0, 32'h5, 20, 10, cyc);
        check("stall_cycles", 128'(cyc), 128'd77);
        check("stall_chain", 128'(dut.chain), 128'h00000005_00000000);

        // configurator reset while DONE blocks further accumulation
        @(negedge clk_i);
        configurator_enable = 1'b0;
        configurator_reset  = 1'b1;
        @(negedge clk_i);
        configurator_reset  = 1'b0;
        check("cfgrst_done", 128'(configurator_done), 128'h0);
        check("cfgrst_state", 128'(dut.state), 128'h0);
        cgra_run(3);
        check("acc_blocked", 128'(cgra_result_o), 128'hFF);

        // fetch front-end
        @(negedge clk_i);
        riscv_enable   = 1'b1;
        fetch_enable_i = 1'b1;
        @(posedge clk_i);
        #1;
        check("f1_valid", 128'(instr_valid_o), 128'h1);
        check("f1_rdata", instr_rdata_o,
              128'h00000004_00000003_00000002_00000001);
        check("f1_pc", 128'(pc_o), 128'h190);
        @(posedge clk_i);
        #1;
        check("f2_rdata", instr_rdata_o,
              128'h00000008_00000007_00000006_00000005);
        check("f2_pc", 128'(pc_o), 128'h1A0);
        @(negedge clk_i);
        fetch_enable_i = 1'b0;
        @(posedge clk_i);
        #1;
        check("idle_valid", 128'(instr_valid_o), 128'h0);
        check("idle_pc", 128'(pc_o), 128'h1A0);
        @(negedge clk_i);
        rst_ni = 1'b0;
        @(posedge clk_i);
        #1;
        check("corerst_pc", 128'(pc_o), 128'h180);
        check("corerst_valid", 128'(instr_valid_o), 128'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
